// File: rtl/cmd_sched_if.sv
// cmd_sched_if: request/response and target-side signals of the command
// scheduler, bundled so the scheduler and its environment share one port.
//   req_valid[1:0]      per-requester request (bit0 UART path, bit1 sequencer)
//   req0_tgt/req1_tgt   target code: 01 MGU, 10 GNU, 11 both, 00 invalid
//   req0_val/req1_val   command value
//   req_ack/req_err     one-cycle consume / reject pulses per requester
//   mgu_busy/gnu_busy   target cannot accept a command
//   mgu_cmd/gnu_cmd     registered command values
//   mgu_stb/gnu_stb     pulse on the cycle the matching cmd register updates
// slave  : the scheduler side.  master : the requester/target environment.
interface cmd_sched_if;
  logic [1:0]  req_valid;
  logic [1:0]  req0_tgt;
  logic [1:0]  req1_tgt;
  logic [15:0] req0_val;
  logic [15:0] req1_val;
  logic [1:0]  req_ack;
  logic [1:0]  req_err;
  logic        mgu_busy;
  logic        gnu_busy;
  logic [15:0] mgu_cmd;
  logic [15:0] gnu_cmd;
  logic        mgu_stb;
  logic        gnu_stb;

  modport slave (
    input  req_valid, req0_tgt, req1_tgt, req0_val, req1_val, mgu_busy, gnu_busy,
    output req_ack, req_err, mgu_cmd, gnu_cmd, mgu_stb, gnu_stb
  );

  modport master (
    output req_valid, req0_tgt, req1_tgt, req0_val, req1_val, mgu_busy, gnu_busy,
    input  req_ack, req_err, mgu_cmd, gnu_cmd, mgu_stb, gnu_stb
  );
endinterface

// File: rtl/cmd_sched.sv
// cmd_sched: arbitrates two command requesters onto two targets (MGU, GNU).
// One request is in service at a time. A granted request waits until every
// addressed target is not busy and past its hold-off window, then updates the
// addressed command registers together; it is rejected on an invalid target
// code or when the wait exceeds TIMEOUT_CYCLES.
//   clk, rst  single clock, synchronous active-high reset
//   bus       cmd_sched_if.slave (requests, acks, target busy, cmd/stb)

// Per-target slice: command register, strobe and hold-off counter.
//   load   update cmd with val this edge and restart the hold-off window
//   busy   target busy input
//   ready  target can take a command now (not busy, hold-off expired)
//   cmd    registered command, stb pulses on the cycle cmd changes
module cmd_sched_tgt #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] val,
  input  logic        busy,
  output logic        ready,
  output logic [15:0] cmd,
  output logic        stb
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [HW-1:0] hold;

  assign ready = !busy && (hold == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd  <= '0;
      stb  <= 1'b0;
      hold <= '0;
    end else begin
      stb <= load;
      if (load) begin
        cmd  <= val;
        // Counts down to zero while the new command is visible, so the
        // next update is spaced exactly HOLD_CYCLES after this one.
        hold <= HW'(HOLD_CYCLES - 1);
      end else if (hold != '0) begin
        hold <= hold - HW'(1);
      end
    end
  end
endmodule

module cmd_sched #(
  parameter int HOLD_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic        clk,
  input logic        rst,
  cmd_sched_if.slave bus
);
  localparam int NT = 2;  // bit0 MGU, bit1 GNU: matches the target code bits
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  state_t               state;
  logic                 prefer;   // requester that wins the next tie
  logic                 win_q;    // requester in service
  logic [1:0]           tgt_q;
  logic [15:0]          val_q;
  logic [TW-1:0]        tcnt;
  logic [1:0]           ack;
  logic [1:0]           err;

  logic [NT-1:0]        busy;
  logic [NT-1:0]        ready;
  logic [NT-1:0]        load;
  logic [NT-1:0]        stb;
  logic [NT-1:0][15:0]  cmd;

  logic                 winner;
  logic [1:0]           win_tgt;
  logic [15:0]          win_val;
  logic                 issue_ok;

  assign busy    = {bus.gnu_busy, bus.mgu_busy};
  assign winner  = (bus.req_valid == 2'b11) ? prefer : bus.req_valid[1];
  assign win_tgt = winner ? bus.req1_tgt : bus.req0_tgt;
  assign win_val = winner ? bus.req1_val : bus.req0_val;

  // Every addressed target ready; unaddressed targets do not matter.
  assign issue_ok = &(ready | ~tgt_q);
  assign load     = (state == WAIT && issue_ok) ? tgt_q : '0;

  generate
    for (genvar i = 0; i < NT; i++) begin : g_tgt
      cmd_sched_tgt #(.HOLD_CYCLES(HOLD_CYCLES)) u_tgt (
        .clk   (clk),
        .rst   (rst),
        .load  (load[i]),
        .val   (val_q),
        .busy  (busy[i]),
        .ready (ready[i]),
        .cmd   (cmd[i]),
        .stb   (stb[i])
      );
    end
  endgenerate

  assign bus.mgu_cmd = cmd[0];
  assign bus.gnu_cmd = cmd[1];
  assign bus.mgu_stb = stb[0];
  assign bus.gnu_stb = stb[1];
  assign bus.req_ack = ack;
  assign bus.req_err = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      prefer <= 1'b0;
      win_q  <= 1'b0;
      tgt_q  <= '0;
      val_q  <= '0;
      tcnt   <= '0;
      ack    <= '0;
      err    <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: begin
          // While an ack is visible the acked requester still holds
          // req_valid; only the cycle after counts as a new request.
          if (bus.req_valid != '0 && ack == '0) begin
            win_q  <= winner;
            prefer <= ~winner;
            tgt_q  <= win_tgt;
            val_q  <= win_val;
            tcnt   <= '0;
            if (win_tgt == 2'b00) begin
              ack <= winner ? 2'b10 : 2'b01;
              err <= winner ? 2'b10 : 2'b01;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (issue_ok) begin
            state <= ISSUE;
            ack   <= win_q ? 2'b10 : 2'b01;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= IDLE;
            ack   <= win_q ? 2'b10 : 2'b01;
            err   <= win_q ? 2'b10 : 2'b01;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ISSUE: state <= IDLE;  // cmd/stb/ack are visible this cycle
        default: state <= IDLE;
      endcase
    end
  end
endmodule
